mcu_multi_cycle_core: RTL and testbench
=======================================

MCU_MULTI_CYCLE_CORE -- requirements
Module: mcu_multi_cycle_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register, ALU and data-memory width (legal 8..32).
REQ-002 SHALL have parameter PC_W, default 16, meaning program-counter and instruction-address width (legal 12..16).
REQ-003 SHALL have parameter R0_ZERO, default 1, meaning 1 = register r0 reads 0 and ignores writes.
REQ-004 SHALL have these ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous reset, active high.
- run_en  in  1  step/run enable; 0 freezes all state.
- imem_addr  out  PC_W  instruction address.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction data valid.
- imem_rdata  in  16  instruction word.
- dmem_addr  out  DATA_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_req  out  1  data access request.
- dmem_ack  in  1  data access complete / load data valid.
- dmem_rdata  in  DATA_W  load data.
- pc  out  PC_W  current PC.
- instr  out  16  latched instruction.
- state  out  3  FSM state code.
- halted  out  1  core in HALT.
- dbg_raddr  in  4  debug register select.
- dbg_rdata  out  DATA_W  combinational read of register dbg_raddr.

Function
REQ-005 SHALL decode instructions with these fields: [15:12] op, [11:8] rs, [7:4] rt, [3:0] rd/imm; imm SHALL be sign-extended to DATA_W (ALU) and PC_W (branch).
REQ-006 SHALL implement these opcodes; any other opcode SHALL be a NOP:
- 0 ADD, 1 SUB, 2 AND, 3 OR: rd = rs op rt.
- 4 ADDI: rt = rs + imm.
- 5 LW: rt = M[rs + imm].
- 6 SW: M[rs + imm] = rt.
- 7 BNE, 8 BEQ: compare rs with rt; if taken, PC = PC+1 + imm.
- 9 J: PC = {(PC+1)[PC_W-1:12], instr[11:0]}; for PC_W = 12 the target is instr[11:0].
- F HALT.
REQ-007 SHALL perform all arithmetic modulo 2^DATA_W (data) and 2^PC_W (PC), with no carry/overflow flags and PC wrap from all-ones to 0.
REQ-008 SHALL use FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to FETCH on the next enabled edge.
REQ-009 FETCH: imem_req=1 and imem_addr=pc; on imem_ack, SHALL latch instr, set pc=pc+1 and go to DECODE; without ack it SHALL stay in FETCH.
REQ-010 DECODE: SHALL latch A=R[rs] and B=R[rt], then go to EXEC; HALT opcode SHALL go to HALT instead.
REQ-011 EXEC, ALU ops and ADDI: SHALL latch the result and go to WB.
REQ-012 EXEC, LW/SW: SHALL latch address A+imm and go to MEM.
REQ-013 EXEC, branch/J: SHALL load pc with the target if taken and go to FETCH.
REQ-014 EXEC, NOP: SHALL go to FETCH.
REQ-015 MEM: dmem_req=1, dmem_we=(op==SW), dmem_addr/dmem_wdata stable; on dmem_ack, LW SHALL latch dmem_rdata and go to WB, SW SHALL go to FETCH.
REQ-016 WB: SHALL write the destination register (rd for R-type, rt for ADDI/LW), then go to FETCH.
REQ-017 HALT: halted=1 and no requests asserted; the core SHALL exit HALT only on clear.
REQ-018 With zero-wait acks, latency SHALL be: ALU/ADDI 4 cycles, LW 5, SW 4, branch/J/NOP 3 per instruction.
REQ-019 When run_en=0, the FSM, pc, instr and registers SHALL hold; req outputs SHALL keep their current value; any ack arriving while run_en=0 SHALL be ignored.
REQ-020 imem_req and dmem_req SHALL never be asserted together.
REQ-021 Register writes to r0 SHALL be discarded when R0_ZERO=1.
REQ-022 Register-file reads SHALL return pre-write values within the same cycle.

Reset
REQ-023 While clear=1, the core SHALL set: pc=0, instr=0, state=FETCH, halted=0, all registers 0, dmem_req=0, dmem_we=0.
REQ-024 imem_req SHALL be 1 once clear falls, with imem_addr=0.
REQ-025 clear asserted mid-MEM or mid-FETCH SHALL abort the access immediately; no register write SHALL occur.

Verification
REQ-026 Zero-wait memory, program ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 -> dbg r3=2 at cycle 12, pc=3.
REQ-027 SW r1 then LW r4 at the same address, with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles each access; r4=5; imem_req never high during MEM.
REQ-028 BNE r1,r2,-2 with r1!=r2 -> pc returns to branch address minus 1; BEQ with equal operands -> taken; not-taken -> pc+1.
REQ-029 PC_W=12, J 0xFFF then fetch -> pc wraps to 0x000 after fetch at 0xFFF.
REQ-030 run_en toggling 1/0 every cycle -> same final register state as continuous run, in exactly twice the cycles.
REQ-031 HALT executed, then clear pulse mid-HALT -> halted=1 until clear, then pc=0, state=FETCH; DATA_W=8, ADDI 127+1 -> 0x80.

Source files
------------

// File: rtl/mcu_multi_cycle_core.sv
// Multi-cycle 16-bit-instruction MCU core: FETCH/DECODE/EXEC/MEM/WB FSM,
// sixteen-entry register file, separate instruction and data ports.
module mcu_multi_cycle_core #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 16,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              run_en,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_req,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic [15:0]       instr,
  output logic [2:0]        state,
  output logic              halted,
  input  logic [3:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BNE  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_J    = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t st;

  logic [DATA_W-1:0] regs [16];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] addr_q;

  logic [3:0] op;
  logic [3:0] rs;
  logic [3:0] rt;
  logic [3:0] rd;

  assign op = instr[15:12];
  assign rs = instr[11:8];
  assign rt = instr[7:4];
  assign rd = instr[3:0];

  logic [DATA_W-1:0] imm_d;
  logic [PC_W-1:0]   imm_p;

  assign imm_d = {{(DATA_W-4){instr[3]}}, instr[3:0]};
  assign imm_p = {{(PC_W-4){instr[3]}}, instr[3:0]};

  logic is_alu;
  logic is_addi;
  logic is_lw;
  logic is_sw;
  logic is_bne;
  logic is_beq;
  logic is_j;

  assign is_alu  = (op == OP_ADD) || (op == OP_SUB) ||
                   (op == OP_AND) || (op == OP_OR);
  assign is_addi = (op == OP_ADDI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_bne  = (op == OP_BNE);
  assign is_beq  = (op == OP_BEQ);
  assign is_j    = (op == OP_J);

  function automatic logic [DATA_W-1:0] rget(input logic [3:0] i);
    if (R0_ZERO != 0 && i == 4'd0) return '0;
    return regs[i];
  endfunction

  logic [DATA_W-1:0] alu;

  always_comb begin
    alu = a_q + b_q;
    case (op)
      OP_SUB:  alu = a_q - b_q;
      OP_AND:  alu = a_q & b_q;
      OP_OR:   alu = a_q | b_q;
      default: alu = a_q + b_q;
    endcase
  end

  // pc already holds PC+1 once EXEC is reached
  logic [PC_W-1:0] j_tgt;

  always_comb begin
    j_tgt       = pc;
    j_tgt[11:0] = instr[11:0];
  end

  logic [3:0] wb_dst;
  logic       wb_ok;

  assign wb_dst = is_alu ? rd : rt;
  assign wb_ok  = !(R0_ZERO != 0 && wb_dst == 4'd0);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      st     <= FETCH;
      pc     <= '0;
      instr  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      addr_q <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (run_en) begin
      case (st)
        FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            pc    <= pc + 1'b1;
            st    <= DECODE;
          end
        end
        DECODE: begin
          a_q <= rget(rs);
          b_q <= rget(rt);
          st  <= (op == OP_HALT) ? HALT : EXEC;
        end
        EXEC: begin
          st <= FETCH;
          unique case (1'b1)
            is_alu: begin
              res_q <= alu;
              st    <= WB;
            end
            is_addi: begin
              res_q <= a_q + imm_d;
              st    <= WB;
            end
            is_lw, is_sw: begin
              addr_q <= a_q + imm_d;
              st     <= MEM;
            end
            is_bne: if (a_q != b_q) pc <= pc + imm_p;
            is_beq: if (a_q == b_q) pc <= pc + imm_p;
            is_j:   pc <= j_tgt;
            default: ;
          endcase
        end
        MEM: begin
          if (dmem_ack) begin
            if (is_lw) begin
              res_q <= dmem_rdata;
              st    <= WB;
            end else begin
              st <= FETCH;
            end
          end
        end
        WB: begin
          if (wb_ok) regs[wb_dst] <= res_q;
          st <= FETCH;
        end
        HALT: st <= HALT;
        default: st <= FETCH;
      endcase
    end
  end

  // Requests decode straight from the state register, so clear drops them at once
  assign imem_req   = (st == FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = (st == MEM);
  assign dmem_we    = (st == MEM) && is_sw;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = b_q;
  assign halted     = (st == HALT);
  assign state      = st;
  assign dbg_rdata  = rget(dbg_raddr);

endmodule

// File: tb/tb_mcu_multi_cycle_core.sv
// Bench for mcu_multi_cycle_core: directed programs plus random programs
// compared against an instruction-level reference model.
module tb_mcu_multi_cycle_core;

  localparam int DW = 16;
  localparam int PW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clear, run_en;
  logic [PW-1:0] imem_addr;
  logic          imem_req, imem_ack;
  logic [15:0]   imem_rdata;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          dmem_we, dmem_req, dmem_ack;
  logic [PW-1:0] pc;
  logic [15:0]   instr;
  logic [2:0]    state;
  logic          halted;
  logic [3:0]    dbg_raddr;
  logic [DW-1:0] dbg_rdata;

  mcu_multi_cycle_core #(.DATA_W(DW), .PC_W(PW), .R0_ZERO(1)) dut (
    .clk(clk), .clear(clear), .run_en(run_en),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .instr(instr), .state(state), .halted(halted),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  logic         clear2, run_en2;
  logic [11:0]  imem_addr2;
  logic         imem_req2, imem_ack2;
  logic [15:0]  imem_rdata2;
  logic [7:0]   dmem_addr2, dmem_wdata2, dmem_rdata2;
  logic         dmem_we2, dmem_req2, dmem_ack2;
  logic [11:0]  pc2;
  logic [15:0]  instr2;
  logic [2:0]   state2;
  logic         halted2;
  logic [3:0]   dbg_raddr2;
  logic [7:0]   dbg_rdata2;

  mcu_multi_cycle_core #(.DATA_W(8), .PC_W(12), .R0_ZERO(1)) dut2 (
    .clk(clk), .clear(clear2), .run_en(run_en2),
    .imem_addr(imem_addr2), .imem_req(imem_req2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
    .dmem_we(dmem_we2), .dmem_req(dmem_req2),
    .dmem_ack(dmem_ack2), .dmem_rdata(dmem_rdata2),
    .pc(pc2), .instr(instr2), .state(state2), .halted(halted2),
    .dbg_raddr(dbg_raddr2), .dbg_rdata(dbg_rdata2)
  );

  logic [15:0]   prog  [256];
  logic [15:0]   prog2 [256];
  logic [DW-1:0] dmem  [256];
  logic [DW-1:0] dimg  [256];
  logic          load_mem;
  int            dly;
  int            dcnt = 0;

  assign imem_ack   = imem_req;
  assign imem_rdata = prog[imem_addr[7:0]];
  assign dmem_ack   = dmem_req && (dcnt >= dly);
  assign dmem_rdata = dmem[dmem_addr[7:0]];

  always @(posedge clk) begin
    if (load_mem) dmem <= dimg;
    else if (dmem_req && dmem_ack && dmem_we && run_en && !clear)
      dmem[dmem_addr[7:0]] <= dmem_wdata;
    dcnt <= dmem_req ? dcnt + 1 : 0;
  end

  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = prog2[imem_addr2[7:0]];
  assign dmem_ack2   = dmem_req2;
  assign dmem_rdata2 = (dmem_addr2 == 8'h00) ? 8'h7F : 8'h00;

  int overlap = 0;
  int run_len = 0;
  int runs[$];

  always @(negedge clk) begin
    if (imem_req && dmem_req) overlap++;
    if (dmem_req) run_len++;
    else if (run_len > 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction-level model: architectural state and per-instruction cycles
  logic [DW-1:0] mr [16];
  logic [DW-1:0] mm [256];
  logic [PW-1:0] mpc;

  task automatic mwr(input logic [3:0] r, input logic [DW-1:0] v);
    if (r != 4'd0) mr[r] = v;
  endtask

  task automatic model_run(input int n, output int cyc);
    logic [15:0]   ins;
    logic [3:0]    mop, s, t, d;
    logic [DW-1:0] a, b, ea, immd;
    logic [PW-1:0] npc;
    int            immv;
    for (int i = 0; i < 16; i++) mr[i] = '0;
    for (int i = 0; i < 256; i++) mm[i] = dimg[i];
    mpc = '0;
    cyc = 0;
    for (int k = 0; k < n; k++) begin
      ins  = prog[mpc[7:0]];
      mop  = ins[15:12];
      s    = ins[11:8];
      t    = ins[7:4];
      d    = ins[3:0];
      immv = int'(ins[3:0]);
      if (ins[3]) immv = immv - 16;
      immd = DW'(immv);
      a    = mr[s];
      b    = mr[t];
      ea   = a + immd;
      npc  = mpc + 1'b1;
      case (mop)
        4'h0: begin mwr(d, a + b); cyc += 4; end
        4'h1: begin mwr(d, a - b); cyc += 4; end
        4'h2: begin mwr(d, a & b); cyc += 4; end
        4'h3: begin mwr(d, a | b); cyc += 4; end
        4'h4: begin mwr(t, ea); cyc += 4; end
        4'h5: begin mwr(t, mm[ea[7:0]]); cyc += 5; end
        4'h6: begin mm[ea[7:0]] = b; cyc += 4; end
        4'h7: begin if (a != b) npc = npc + PW'(immv); cyc += 3; end
        4'h8: begin if (a == b) npc = npc + PW'(immv); cyc += 3; end
        4'h9: begin npc = {npc[15:12], ins[11:0]}; cyc += 3; end
        default: cyc += 3;
      endcase
      mpc = npc;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear    = 1'b1;
    run_en   = 1'b1;
    load_mem = 1'b1;
    @(negedge clk);
    load_mem = 1'b0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic run(input int n);
    run_en = 1'b1;
    repeat (n) @(negedge clk);
    run_en = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] r,
                         input logic [DW-1:0] exp);
    dbg_raddr = r;
    #1;
    chk($sformatf("%s r%0d", tag, r), dbg_rdata, exp);
  endtask

  task automatic chk_model(input string tag);
    for (int i = 0; i < 16; i++) chk_reg(tag, 4'(i), mr[i]);
    chk({tag, " pc"}, pc, mpc);
    chk({tag, " state"}, state, 3'd0);
  endtask

  task automatic clr_prog();
    for (int i = 0; i < 256; i++) begin
      prog[i] = 16'hA000;
      dimg[i] = '0;
    end
  endtask

  int cyc;
  int base;
  int ov0;

  initial begin
    clear = 1'b1; run_en = 1'b1; load_mem = 1'b0; dly = 0;
    dbg_raddr = 4'd0;
    clear2 = 1'b1; run_en2 = 1'b1; dbg_raddr2 = 4'd2;
    for (int i = 0; i < 256; i++) prog2[i] = 16'hA000;
    prog2[0] = 16'h5010;
    prog2[1] = 16'h4121;
    prog2[2] = 16'h9FFF;

    clr_prog();
    prog[0] = 16'h4015;
    prog[1] = 16'h402D;
    prog[2] = 16'h0123;
    @(negedge clk);
    clear    = 1'b1;
    load_mem = 1'b1;
    @(negedge clk);
    load_mem = 1'b0;
    chk("rst pc", pc, 16'h0);
    chk("rst instr", instr, 16'h0);
    chk("rst state", state, 3'd0);
    chk("rst halted", halted, 1'b0);
    chk("rst dmem_req", dmem_req, 1'b0);
    chk("rst dmem_we", dmem_we, 1'b0);
    chk_reg("rst", 4'd5, '0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("post rst imem_req", imem_req, 1'b1);
    chk("post rst imem_addr", imem_addr, 16'h0);
    run(12);
    chk_reg("alu", 4'd1, 16'd5);
    chk_reg("alu", 4'd2, 16'hFFFD);
    chk_reg("alu", 4'd3, 16'd2);
    chk("alu pc", pc, 16'd3);
    chk("alu state", state, 3'd0);

    clr_prog();
    prog[0] = 16'h4015;
    prog[1] = 16'h4057;
    prog[2] = 16'h6510;
    prog[3] = 16'h5540;
    dly = 3;
    do_reset();
    base = runs.size();
    ov0  = overlap;
    run(23);
    chk_reg("mem", 4'd4, 16'd5);
    chk("mem pc", pc, 16'd4);
    chk("mem stored", dmem[7], 16'd5);
    chk("mem accesses", runs.size() - base, 2);
    if (runs.size() - base >= 2) begin
      chk("sw req cycles", runs[base], 4);
      chk("lw req cycles", runs[base+1], 4);
    end
    chk("req overlap", overlap - ov0, 0);
    dly = 0;

    clr_prog();
    prog[0] = 16'h4011;
    prog[1] = 16'h4022;
    prog[2] = 16'h8125;
    prog[3] = 16'h712E;
    do_reset();
    run(11);
    chk("beq not taken pc", pc, 16'd3);
    run(3);
    chk("bne taken pc", pc, 16'd2);

    clr_prog();
    prog[0] = 16'h4011;
    prog[1] = 16'h4021;
    prog[2] = 16'h8123;
    do_reset();
    run(11);
    chk("beq taken pc", pc, 16'd6);

    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 256; i++) begin
        prog[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        dimg[i] = DW'($urandom);
      end
      model_run(60, cyc);
      do_reset();
      run(cyc);
      chk_model($sformatf("rand%0d", s));
    end

    do_reset();
    repeat (2 * cyc) begin
      @(negedge clk);
      run_en = ~run_en;
    end
    run_en = 1'b0;
    chk_model("toggle");

    clr_prog();
    prog[0] = 16'h4015;
    prog[1] = 16'hF000;
    do_reset();
    run(6);
    chk("halt halted", halted, 1'b1);
    chk("halt state", state, 3'd5);
    chk("halt imem_req", imem_req, 1'b0);
    chk("halt dmem_req", dmem_req, 1'b0);
    run(10);
    chk("halt stays", halted, 1'b1);
    chk("halt pc", pc, 16'd2);
    clear = 1'b1;
    #1;
    chk("halt clr halted", halted, 1'b0);
    chk("halt clr pc", pc, 16'd0);
    chk("halt clr state", state, 3'd0);
    @(negedge clk);
    clear = 1'b0;

    clr_prog();
    prog[0] = 16'h4057;
    prog[1] = 16'h5540;
    dimg[7] = 16'h1234;
    dly = 10;
    do_reset();
    run(9);
    chk("abort in mem", dmem_req, 1'b1);
    clear = 1'b1;
    #1;
    chk("abort dmem_req", dmem_req, 1'b0);
    chk("abort state", state, 3'd0);
    chk_reg("abort", 4'd4, '0);
    @(negedge clk);
    dly = 0;
    clear = 1'b0;

    @(negedge clk);
    clear2 = 1'b0;
    repeat (9) @(negedge clk);
    chk("w8 addi wrap", dbg_rdata2, 8'h80);
    chk("w8 halted", halted2, 1'b0);
    repeat (3) @(negedge clk);
    chk("pc12 jump", pc2, 12'hFFF);
    repeat (1) @(negedge clk);
    chk("pc12 wrap", pc2, 12'h000);
    chk("pc12 state", state2, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
